// File: rtl/beamscaler_servo.sv
// rtl/beamscaler_servo.sv - per-beam threshold servo driven by scaler updates
// Optional deadband input enabled by defining BEAMSERVO_DEADBAND_EN.
module beamscaler_servo #(
   parameter int          NBEAMS   = 46,
   parameter logic [17:0] THR_INIT = 18'h10000
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        done_i,
   output logic        scal_rd_o,
   output logic [7:0]  scal_adr_o,
   input  logic [31:0] scal_dat_i,
   input  logic        servo_en_i,
   input  logic [11:0] target_i,
   input  logic [7:0]  step_i,
`ifdef BEAMSERVO_DEADBAND_EN
   input  logic [7:0]  deadband_i,
`endif
   input  logic        thr_wr_i,
   input  logic [5:0]  thr_wr_idx_i,
   input  logic [17:0] thr_wr_dat_i,
   output logic        thr_valid_o,
   output logic [5:0]  thr_idx_o,
   output logic [17:0] thr_dat_o,
   output logic        thr_update_o,
   output logic        busy_o,
   output logic        overrun_o
);

   localparam int NPAIR = (NBEAMS + 1) / 2;
   localparam int AW    = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_WAIT1, S_WAIT2, S_PROC_LO, S_PROC_HI, S_FINISH
   } state_t;

   state_t      state;
   logic [4:0]  pair;
   logic [31:0] scal_q;
   logic        pend;
   logic [17:0] thr_mem [NBEAMS];

   logic        wr_q;
   logic [5:0]  wr_idx_q;
   logic [17:0] wr_dat_q;

   logic        req;
   logic [7:0]  dband;
   logic [5:0]  beam;
   logic        beam_ok;
   logic [11:0] scal;
   logic [17:0] thr_cur;
   logic [17:0] thr_new;
   logic [12:0] hi_lim;
   logic [12:0] lo_lim;
   logic [18:0] sum_up;
   logic        unused_ok;

   assign req       = done_i & servo_en_i;
   assign unused_ok = ^{scal_q[31:28], scal_q[15:12]};

`ifdef BEAMSERVO_DEADBAND_EN
   assign dband = deadband_i;
`else
   assign dband = 8'd0;
`endif

   always_comb begin
      beam    = {pair, (state == S_PROC_HI)};
      beam_ok = ((state == S_PROC_LO) || (state == S_PROC_HI)) &&
                ({1'b0, beam} < 7'(NBEAMS));
      scal    = (state == S_PROC_HI) ? scal_q[27:16] : scal_q[11:0];
      thr_cur = thr_mem[beam[AW-1:0]];
      hi_lim  = {1'b0, target_i} + {5'b0, dband};
      lo_lim  = (target_i >= {4'b0, dband}) ? {1'b0, target_i - {4'b0, dband}} : 13'd0;
      sum_up  = {1'b0, thr_cur} + {11'b0, step_i};
      if ({1'b0, scal} > hi_lim)
         thr_new = sum_up[18] ? 18'h3FFFF : sum_up[17:0];
      else if ({1'b0, scal} < lo_lim)
         thr_new = (thr_cur < {10'b0, step_i}) ? 18'd0 : thr_cur - {10'b0, step_i};
      else
         thr_new = thr_cur;
      // A software write landing on the beam being serviced overrides the servo step
      if (wr_q && (wr_idx_q == beam))
         thr_new = wr_dat_q;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state        <= S_IDLE;
         pair         <= 5'd0;
         scal_q       <= 32'd0;
         pend         <= 1'b0;
         wr_q         <= 1'b0;
         wr_idx_q     <= 6'd0;
         wr_dat_q     <= 18'd0;
         scal_rd_o    <= 1'b0;
         scal_adr_o   <= 8'd0;
         thr_valid_o  <= 1'b0;
         thr_idx_o    <= 6'd0;
         thr_dat_o    <= 18'd0;
         thr_update_o <= 1'b0;
         busy_o       <= 1'b0;
         overrun_o    <= 1'b0;
         for (int i = 0; i < NBEAMS; i++)
            thr_mem[i] <= THR_INIT;
      end else begin
         scal_rd_o    <= 1'b0;
         thr_valid_o  <= 1'b0;
         thr_update_o <= 1'b0;

         wr_q     <= thr_wr_i && ({1'b0, thr_wr_idx_i} < 7'(NBEAMS));
         wr_idx_q <= thr_wr_idx_i;
         wr_dat_q <= thr_wr_dat_i;
         if (wr_q)
            thr_mem[wr_idx_q[AW-1:0]] <= wr_dat_q;

         if (beam_ok) begin
            thr_mem[beam[AW-1:0]] <= thr_new;
            thr_valid_o           <= 1'b1;
            thr_idx_o             <= beam;
            thr_dat_o             <= thr_new;
         end

         // One request can queue behind a running cycle; anything beyond that is lost
         if (req && (state != S_IDLE)) begin
            if (pend)
               overrun_o <= 1'b1;
            else if (state != S_FINISH)
               pend <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (req) begin
                  state      <= S_READ;
                  pair       <= 5'd0;
                  scal_rd_o  <= 1'b1;
                  scal_adr_o <= 8'd0;
                  busy_o     <= 1'b1;
               end
            end
            S_READ:    state <= S_WAIT1;
            S_WAIT1:   state <= S_WAIT2;
            S_WAIT2: begin
               scal_q <= scal_dat_i;
               state  <= S_PROC_LO;
            end
            S_PROC_LO: state <= S_PROC_HI;
            S_PROC_HI: begin
               if (pair == 5'(NPAIR - 1)) begin
                  state <= S_FINISH;
               end else begin
                  state      <= S_READ;
                  pair       <= 5'(pair + 5'd1);
                  scal_rd_o  <= 1'b1;
                  scal_adr_o <= {3'b0, 5'(pair + 5'd1)};
               end
            end
            S_FINISH: begin
               thr_update_o <= 1'b1;
               if (pend || req) begin
                  state      <= S_READ;
                  pend       <= 1'b0;
                  pair       <= 5'd0;
                  scal_rd_o  <= 1'b1;
                  scal_adr_o <= 8'd0;
               end else begin
                  state  <= S_IDLE;
                  busy_o <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/beamscaler_servo.md
# beamscaler_servo

Per-beam threshold servo in the `wb_clk_i` domain, directly downstream of the beam scaler bank. On each scaler-update-done pulse it reads every real-beam scaler from the scaler RAM read port. It compares each scaler against a software target and steps that beam's 18-bit trigger threshold up or down, saturating at the range limits. The updated thresholds are streamed to the beamformer threshold registers, followed by an update strobe.

## Interface
- `NBEAMS`, 46: number of beams serviced (1–64).
- `THR_INIT`, 18'h10000: reset/initial threshold value for every beam.
- `wb_clk_i` input 1: sole clock.
- `wb_rst_i` input 1: synchronous, active-high reset.
- `done_i` input 1: one-cycle pulse from the scaler bank; a fresh scaler set is readable.
- `scal_rd_o` output 1: scaler RAM read enable.
- `scal_adr_o` output 8: scaler RAM word address; real-beam pair k is at address k.
- `scal_dat_i` input 32: scaler word; bits [11:0] = beam 2k, bits [27:16] = beam 2k+1; valid 2 cycles after `scal_rd_o`.
- `servo_en_i` input 1: enables servo cycles.
- `target_i` input 12: target scaler count.
- `step_i` input 8: threshold step magnitude.
- `deadband_i` input 8: deadband half-width; present only with `BEAMSERVO_DEADBAND_EN`.
- `thr_wr_i` input 1: software threshold write strobe.
- `thr_wr_idx_i` input 6: beam index for the software write.
- `thr_wr_dat_i` input 18: software threshold value.
- `thr_valid_o` output 1: one-cycle qualifier for `thr_idx_o`/`thr_dat_o`.
- `thr_idx_o` output 6: beam index of the streamed threshold.
- `thr_dat_o` output 18: streamed threshold value.
- `thr_update_o` output 1: one-cycle strobe; the full threshold set has been streamed.
- `busy_o` output 1: servo cycle in progress.
- `overrun_o` output 1: sticky flag; cleared only by reset.

## Operation
- Internal threshold array: NBEAMS × 18 bits, every entry initialised to `THR_INIT` on reset. The number of RAM pairs read is NPAIR = ceil(NBEAMS/2).
- FSM states and transitions:
  - IDLE → READ on `done_i` && `servo_en_i`.
  - READ → WAIT1 → WAIT2 → PROC_LO → PROC_HI.
  - PROC_HI → READ with pair+1 while pair < NPAIR-1, else → FINISH.
  - FINISH → IDLE.
- READ: `scal_rd_o`=1, `scal_adr_o`=pair. WAIT2: capture `scal_dat_i`.
- PROC_LO processes beam 2·pair; PROC_HI processes beam 2·pair+1. When NBEAMS is odd, the last PROC_HI performs no update and no stream.
- Update rule for scaler s, threshold t, target T, step S, deadband D (D=0 without the macro):
  - s > T+D: t ← min(t+S, 2^18−1).
  - s < T−D: t ← max(t−S, 0).
  - Otherwise t is unchanged.
  - T+D and T−D are computed in 13-bit arithmetic; T−D clamps at 0.
- Every processed beam is streamed, changed or not. The write-back value is `thr_dat_o`.
- `done_i` while `busy_o`: latch one pending request and start READ directly from FINISH. A second `done_i` while a request is already pending sets `overrun_o` and is dropped.
- `servo_en_i` low at `done_i`: the pulse is ignored and nothing is latched. Deasserting `servo_en_i` mid-cycle does not abort the cycle.
- `thr_wr_i`: writes the array entry in the following cycle, in any state. If it hits the beam being updated in the same cycle, the software write wins and that beam's stream carries the software value.
- `thr_wr_idx_i` ≥ NBEAMS: the write is ignored.
- Reset mid-operation: FSM → IDLE, pending request cleared, array reloaded to `THR_INIT`, all outputs set to reset values.

## Timing
- Reset values:
  - `scal_rd_o`=0, `scal_adr_o`=0, `thr_valid_o`=0, `thr_idx_o`=0, `thr_dat_o`=0.
  - `thr_update_o`=0, `busy_o`=0, `overrun_o`=0.
- `done_i` in cycle n → `scal_rd_o` high in n+1. Data is captured in n+3.
- `thr_valid_o` is high in the cycle after PROC_LO/PROC_HI: two one-cycle pulses, back to back, per pair.
- Cost is 5 cycles per pair. For NBEAMS=46 the cycle is 23·5 = 115 cycles.
- `thr_update_o` is asserted in the cycle after FINISH.
- `busy_o` is high from READ through FINISH inclusive.

## Configuration
- `BEAMSERVO_DEADBAND_EN` defined: the `deadband_i` port exists, and D = `deadband_i`.
- Not defined: the port is absent, D=0, and any mismatch steps the threshold.

## Test plan
- NBEAMS=4, T=100, S=16; scalers {200,50,100,100}; pulse `done_i` → thresholds {0x10010, 0x0FFF0, 0x10000, 0x10000} streamed on idx 0..3, then `thr_update_o`.
- Saturation: preload beam 0 via `thr_wr_i` to 0x3FFF8, S=16, s=4095 → streams 0x3FFFF. Preload 0x00005, s=0 → streams 0.
- NBEAMS=5: only 5 `thr_valid_o` pulses over 3 pairs; `scal_adr_o` sequence 0,1,2; `thr_update_o` 1 cycle after FINISH.
- `done_i` twice during a cycle → second servo cycle follows immediately and `overrun_o`=0. Three pulses → `overrun_o`=1, exactly two cycles run.
- `BEAMSERVO_DEADBAND_EN`, T=100, D=10: s=109 → unchanged; s=111 → +S; s=89 → −S. With T=5, D=10: s=0 → unchanged.
- Assert `wb_rst_i` in WAIT2 of pair 1 → next cycle `busy_o`=0, no further `thr_valid_o`, array reads back `THR_INIT`.
